// File: rtl/heap_stack_scrubber.sv
`default_nettype none
// ============================================================================
// Module   : heap_stack_scrubber
// Purpose  : Owns the Avalon port of the heap/stack RAM. Forwards CPU
//            accesses while idle. On a start request it takes over the RAM
//            and fills a word range with a fixed pattern, stalling the CPU.
// Options  : HEAP_STACK_SCRUB_VERIFY_EN - read back the filled range after
//            the fill and flag the first word that does not hold the pattern.
// Revision : 1.0 - initial release
// ============================================================================
module heap_stack_scrubber #(
    parameter int ADDR_W = 13,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 5000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     base,
    input  logic [ADDR_W-1:0]     length,
    input  logic [DATA_W-1:0]     pattern,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_W-1:0]     err_addr,
    input  logic [ADDR_W-1:0]     cpu_address,
    input  logic [DATA_W/8-1:0]   cpu_byteenable,
    input  logic                  cpu_chipselect,
    input  logic                  cpu_write,
    input  logic [DATA_W-1:0]     cpu_writedata,
    output logic [DATA_W-1:0]     cpu_readdata,
    output logic                  cpu_waitrequest,
    output logic [ADDR_W-1:0]     mem_address,
    output logic [DATA_W/8-1:0]   mem_byteenable,
    output logic                  mem_chipselect,
    output logic                  mem_write,
    output logic [DATA_W-1:0]     mem_writedata,
    output logic                  mem_clken,
    input  logic [DATA_W-1:0]     mem_readdata
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_FILL   = 2'd1;
`ifdef HEAP_STACK_SCRUB_VERIFY_EN
    localparam logic [1:0] S_VERIFY = 2'd2;
`endif

    localparam logic [ADDR_W:0]   c_DEPTH  = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0]   c_ONE_X  = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] c_ONE    = ADDR_W'(1);

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_end;
    logic [DATA_W-1:0] r_pattern;
    logic              r_done;

    logic [ADDR_W:0]   w_sum;
    logic [ADDR_W:0]   w_lim;
    logic              w_noop;
    logic              w_last;

`ifdef HEAP_STACK_SCRUB_VERIFY_EN
    logic [ADDR_W-1:0] r_base;
    logic              r_drain;
    logic              r_cmp_valid;
    logic [ADDR_W-1:0] r_cmp_addr;
    logic              r_err;
    logic [ADDR_W-1:0] r_err_addr;
`endif

    // Range arithmetic is one bit wider than the address so base+length cannot wrap
    always_comb begin
        w_sum  = {1'b0, base} + {1'b0, length};
        w_lim  = (w_sum > c_DEPTH) ? c_DEPTH : w_sum;
        w_noop = (length == '0) || ({1'b0, base} >= c_DEPTH);
        w_last = (r_addr == r_end);
    end

    // Engine sequencing: accept start, walk the fill range, optionally walk it again to verify
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_addr    <= '0;
            r_end     <= '0;
            r_pattern <= '0;
            r_done    <= 1'b0;
`ifdef HEAP_STACK_SCRUB_VERIFY_EN
            r_base    <= '0;
            r_drain   <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_addr    <= base;
                        r_end     <= ADDR_W'(w_lim - c_ONE_X);
                        r_pattern <= pattern;
`ifdef HEAP_STACK_SCRUB_VERIFY_EN
                        r_base    <= base;
                        r_drain   <= 1'b0;
`endif
                        if (w_noop) begin
                            r_done <= 1'b1;
                        end else begin
                            r_state <= S_FILL;
                        end
                    end
                end
                S_FILL: begin
                    if (w_last) begin
`ifdef HEAP_STACK_SCRUB_VERIFY_EN
                        r_state <= S_VERIFY;
                        r_addr  <= r_base;
`else
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
`endif
                    end else begin
                        r_addr <= r_addr + c_ONE;
                    end
                end
`ifdef HEAP_STACK_SCRUB_VERIFY_EN
                S_VERIFY: begin
                    // One extra cycle after the last read lets its data be compared
                    if (r_drain) begin
                        r_state <= S_IDLE;
                        r_drain <= 1'b0;
                        r_done  <= 1'b1;
                    end else if (w_last) begin
                        r_drain <= 1'b1;
                    end else begin
                        r_addr <= r_addr + c_ONE;
                    end
                end
`endif
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef HEAP_STACK_SCRUB_VERIFY_EN
    // Read data returns one cycle after its address; compare it and keep only the first miss
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cmp_valid <= 1'b0;
            r_cmp_addr  <= '0;
            r_err       <= 1'b0;
            r_err_addr  <= '0;
        end else begin
            r_cmp_valid <= (r_state == S_VERIFY) && !r_drain;
            r_cmp_addr  <= r_addr;
            if ((r_state == S_IDLE) && start) begin
                r_err      <= 1'b0;
                r_err_addr <= '0;
            end else if (r_cmp_valid && (mem_readdata != r_pattern) && !r_err) begin
                r_err      <= 1'b1;
                r_err_addr <= r_cmp_addr;
            end
        end
    end

    assign err      = r_err;
    assign err_addr = r_err_addr;
`else
    assign err      = 1'b0;
    assign err_addr = '0;
`endif

    // RAM port mux: CPU passthrough when idle, engine drives the RAM otherwise
    always_comb begin
        mem_address     = cpu_address;
        mem_byteenable  = cpu_byteenable;
        mem_chipselect  = cpu_chipselect;
        mem_write       = cpu_write;
        mem_writedata   = cpu_writedata;
        cpu_waitrequest = 1'b0;
        case (r_state)
            S_FILL: begin
                mem_address     = r_addr;
                mem_byteenable  = '1;
                mem_chipselect  = 1'b1;
                mem_write       = 1'b1;
                mem_writedata   = r_pattern;
                cpu_waitrequest = cpu_chipselect;
            end
`ifdef HEAP_STACK_SCRUB_VERIFY_EN
            S_VERIFY: begin
                mem_address     = r_addr;
                mem_byteenable  = '1;
                mem_chipselect  = !r_drain;
                mem_write       = 1'b0;
                mem_writedata   = r_pattern;
                cpu_waitrequest = cpu_chipselect;
            end
`endif
            default: ;
        endcase
    end

    assign busy         = (r_state != S_IDLE);
    assign done         = r_done;
    assign cpu_readdata = mem_readdata;
    assign mem_clken    = 1'b1;

endmodule
`default_nettype wire

// File: tb/tb_heap_stack_scrubber.sv
`default_nettype none
// ============================================================================
// Module   : tb_heap_stack_scrubber
// Purpose  : Self-checking bench for heap_stack_scrubber with a behavioural
//            RAM and a range-level reference of what each fill must do.
//            HEAP_STACK_SCRUB_VERIFY_EN selects the read-back expectations.
// Revision : 1.0 - initial release
// ============================================================================
module tb_heap_stack_scrubber;

    localparam int ADDR_W = 13;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 5000;
`ifdef HEAP_STACK_SCRUB_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif

    logic              clk;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] base;
    logic [ADDR_W-1:0] length;
    logic [DATA_W-1:0] pattern;
    logic              busy;
    logic              done;
    logic              err;
    logic [ADDR_W-1:0] err_addr;
    logic [ADDR_W-1:0] cpu_address;
    logic [3:0]        cpu_byteenable;
    logic              cpu_chipselect;
    logic              cpu_write;
    logic [DATA_W-1:0] cpu_writedata;
    logic [DATA_W-1:0] cpu_readdata;
    logic              cpu_waitrequest;
    logic [ADDR_W-1:0] mem_address;
    logic [3:0]        mem_byteenable;
    logic              mem_chipselect;
    logic              mem_write;
    logic [DATA_W-1:0] mem_writedata;
    logic              mem_clken;
    logic [DATA_W-1:0] mem_readdata;

    heap_stack_scrubber #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .start(start), .base(base), .length(length),
        .pattern(pattern), .busy(busy), .done(done), .err(err), .err_addr(err_addr),
        .cpu_address(cpu_address), .cpu_byteenable(cpu_byteenable),
        .cpu_chipselect(cpu_chipselect), .cpu_write(cpu_write),
        .cpu_writedata(cpu_writedata), .cpu_readdata(cpu_readdata),
        .cpu_waitrequest(cpu_waitrequest), .mem_address(mem_address),
        .mem_byteenable(mem_byteenable), .mem_chipselect(mem_chipselect),
        .mem_write(mem_write), .mem_writedata(mem_writedata),
        .mem_clken(mem_clken), .mem_readdata(mem_readdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: byte-enabled write, registered read, one cycle latency
    logic [DATA_W-1:0] ram     [0:DEPTH-1];
    logic [DATA_W-1:0] exp_ram [0:DEPTH-1];
    always @(posedge clk) begin
        if (mem_clken && mem_chipselect) begin
            if (int'(mem_address) < DEPTH) begin
                mem_readdata <= ram[mem_address];
                if (mem_write)
                    for (int b = 0; b < 4; b++)
                        if (mem_byteenable[b]) ram[mem_address][8*b +: 8] = mem_writedata[8*b +: 8];
            end else begin
                mem_readdata <= '0;
            end
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Activity log sampled mid-cycle
    int                wr_addr_q[$];
    int                wr_cyc_q[$];
    logic [DATA_W-1:0] wr_data_q[$];
    int                done_q[$];
    int                busy_cnt = 0;
    always @(negedge clk) begin
        if (mem_chipselect && mem_write) begin
            wr_addr_q.push_back(int'(mem_address));
            wr_cyc_q.push_back(cyc);
            wr_data_q.push_back(mem_writedata);
        end
        if (done) done_q.push_back(cyc);
        if (busy) busy_cnt++;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        assert (obs === exp_v) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        wr_addr_q.delete(); wr_cyc_q.delete(); wr_data_q.delete(); done_q.delete();
        busy_cnt = 0;
    endtask

    task automatic wait_done(input int limit);
        for (int t = 0; t < limit; t++) begin
            if (done_q.size() > 0) break;
            step();
        end
        repeat (3) step();
    endtask

    // Words a request covers: nothing for an empty or out-of-range request, else clamped at DEPTH
    function automatic int clamp_count(input int b, input int l);
        int last;
        if (l == 0 || b >= DEPTH) return 0;
        last = (b + l > DEPTH) ? DEPTH : b + l;
        return last - b;
    endfunction

    task automatic check_image(input string tag);
        int nd = 0;
        for (int a = 0; a < DEPTH; a++) if (ram[a] !== exp_ram[a]) nd++;
        check(tag, nd, 0);
    endtask

    // Compare the logged activity of one fill against the range-level expectation
    task automatic check_fill(input string tag, input int k, input int m, input int b,
                              input logic [DATA_W-1:0] p, input bit exp_err);
        int nbad_wr = 0;
        int exp_done, exp_busy, dc;
        for (int i = 0; i < wr_addr_q.size() && i < m; i++)
            if (wr_addr_q[i] != b + i || wr_cyc_q[i] != k + 1 + i || wr_data_q[i] !== p) nbad_wr++;
        exp_done = (m == 0) ? k + 1 : (VERIFY ? k + 2*m + 2 : k + m + 1);
        exp_busy = (m == 0) ? 0 : (VERIFY ? 2*m + 1 : m);
        dc = (done_q.size() > 0) ? done_q[0] : -1;
        check({tag, "_nwrites"}, wr_addr_q.size(), m);
        check({tag, "_wrseq"}, nbad_wr, 0);
        check({tag, "_ndone"}, done_q.size(), 1);
        check({tag, "_donecyc"}, dc, exp_done);
        check({tag, "_busycyc"}, busy_cnt, exp_busy);
        if (!exp_err) check({tag, "_err"}, err, 0);
        check_image({tag, "_image"});
    endtask

    task automatic run_fill(input string tag, input int b, input int l, input logic [DATA_W-1:0] p);
        int k, m;
        clear_logs();
        base = ADDR_W'(b); length = ADDR_W'(l); pattern = p; start = 1'b1;
        k = cyc;
        step();
        start = 1'b0;
        wait_done(200);
        m = clamp_count(b, l);
        for (int i = 0; i < m; i++) exp_ram[b + i] = p;
        check_fill(tag, k, m, b, p, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, m, stall;
        logic [DATA_W-1:0] p;
        for (int a = 0; a < DEPTH; a++) begin ram[a] = '0; exp_ram[a] = '0; end
        reset = 1'b1; start = 1'b0; base = '0; length = '0; pattern = '0;
        cpu_address = '0; cpu_byteenable = '0; cpu_chipselect = 1'b0;
        cpu_write = 1'b0; cpu_writedata = '0;
        repeat (3) step();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_erraddr", err_addr, 0);
        check("rst_memwrite", mem_write, 0);
        check("rst_clken", mem_clken, 1);
        reset = 1'b0;
        step();

        // CPU passthrough: partial-byte write then read back
        cpu_address = 13'h010; cpu_byteenable = 4'b0011; cpu_chipselect = 1'b1;
        cpu_write = 1'b1; cpu_writedata = 32'hDEADBEEF;
        #1;
        check("pt_wait_wr", cpu_waitrequest, 0);
        step();
        cpu_write = 1'b0;
        #1;
        check("pt_wait_rd", cpu_waitrequest, 0);
        step();
        cpu_chipselect = 1'b0;
        exp_ram[16] = 32'h0000BEEF;
        check("pt_readback", cpu_readdata, 32'h0000BEEF);
        step();

        // Directed fills and boundaries
        run_fill("basic", 100, 8, 32'hA5A5A5A5);
        run_fill("clamp", 4995, 20, 32'h12345678);
        run_fill("len0", 50, 0, 32'hFFFFFFFF);
        run_fill("oor", 6000, 5, 32'hFFFFFFFF);
        run_fill("lastword", 4999, 1, 32'h0BADF00D);

        // Contention: CPU read stalled during a 16-word fill, second start ignored
        clear_logs();
        p = $urandom();
        base = 13'd200; length = 13'd16; pattern = p; start = 1'b1;
        k = cyc;
        step(); start = 1'b0;
        step(); step();
        cpu_address = 13'd205; cpu_byteenable = 4'hF; cpu_chipselect = 1'b1; cpu_write = 1'b0;
        stall = 0;
        for (int t = 0; t < 40; t++) begin
            if (cyc == k + 5) begin
                start = 1'b1; base = 13'd300; length = 13'd4; pattern = ~p;
            end else begin
                start = 1'b0;
            end
            #1;
            if (!cpu_waitrequest) break;
            stall++;
            step();
        end
        start = 1'b0;
        check("cont_stall", stall, 16 - 2);
        step();
        cpu_chipselect = 1'b0;
        check("cont_readdata", cpu_readdata, p);
        repeat (3) step();
        for (int i = 0; i < 16; i++) exp_ram[200 + i] = p;
        check_fill("cont", k, 16, 200, p, 1'b0);

        // Reset during the 4th write of a 10-word fill
        for (int i = 0; i < 10; i++) begin
            ram[400 + i] = $urandom();
            exp_ram[400 + i] = ram[400 + i];
        end
        clear_logs();
        p = $urandom();
        base = 13'd400; length = 13'd10; pattern = p; start = 1'b1;
        step(); start = 1'b0;
        step(); step(); step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rmid_busy", busy, 0);
        check("rmid_done", done, 0);
        repeat (5) step();
        for (int i = 0; i < 4; i++) exp_ram[400 + i] = p;
        check("rmid_nwrites", wr_addr_q.size(), 4);
        check("rmid_ndone", done_q.size(), 0);
        check_image("rmid_image");

        // Randomized fills, some placed to straddle the top of the RAM
        for (int r = 0; r < 8; r++) begin
            int rb, rl;
            if ($urandom_range(0, 2) == 0) rb = $urandom_range(4960, 6200);
            else                           rb = $urandom_range(0, 4900);
            rl = $urandom_range(0, 40);
            run_fill("rand", rb, rl, $urandom());
        end

`ifdef HEAP_STACK_SCRUB_VERIFY_EN
        // Corrupt two words after they are written; only the first one is reported
        clear_logs();
        p = $urandom();
        base = 13'd600; length = 13'd8; pattern = p; start = 1'b1;
        k = cyc;
        step(); start = 1'b0;
        while (cyc < k + 9) step();
        ram[603] = ~p; exp_ram[603] = ~p;
        ram[606] = p ^ 32'h1; exp_ram[606] = p ^ 32'h1;
        wait_done(200);
        for (int i = 0; i < 8; i++) if (i != 3 && i != 6) exp_ram[600 + i] = p;
        check_fill("vfy", k, 8, 600, p, 1'b1);
        check("vfy_err", err, 1);
        check("vfy_erraddr", err_addr, 603);
        run_fill("vfy_clear", 10, 0, 32'h0);
        check("vfy_erraddr_clr", err_addr, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
